divider_n_bits: RTL and testbench



---
 rtl/divider_n_bits.sv | 118 +++++++++++
 tb/tb_divider_n_bits.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/divider_n_bits.sv
// Sequential unsigned divider by repeated subtraction: quotient = dividend / divisor.
// Define DIV_ABORT_EN to add an abort input that cancels a running division.
module divider_n_bits #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         aclr_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
`ifdef DIV_ABORT_EN
  input  logic         abort,
`endif
  output logic         busy,
  output logic         done,
  output logic         div_by_zero,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SUB  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  logic [1:0]   state_reg, state_next;
  logic [N-1:0] quo_reg, quo_next;
  logic [N-1:0] rem_reg, rem_next;
  logic [N-1:0] dvs_reg, dvs_next;
  logic         busy_reg, busy_next;
  logic         done_reg, done_next;
  logic         dbz_reg, dbz_next;
  logic         abort_req;

`ifdef DIV_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    quo_next   = quo_reg;
    rem_next   = rem_reg;
    dvs_next   = dvs_reg;
    busy_next  = busy_reg;
    done_next  = 1'b0;
    dbz_next   = dbz_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          rem_next = dividend;
          if (divisor == '0) begin
            // No subtraction possible: report saturated quotient immediately.
            quo_next   = '1;
            dbz_next   = 1'b1;
            done_next  = 1'b1;
            state_next = ST_DONE;
          end else begin
            quo_next   = '0;
            dvs_next   = divisor;
            dbz_next   = 1'b0;
            busy_next  = 1'b1;
            state_next = ST_SUB;
          end
        end
      end
      ST_SUB: begin
        if (abort_req) begin
          busy_next  = 1'b0;
          state_next = ST_IDLE;
        end else if (rem_reg >= dvs_reg) begin
          rem_next = rem_reg - dvs_reg;
          quo_next = quo_reg + ONE;
        end else begin
          busy_next  = 1'b0;
          done_next  = 1'b1;
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        busy_next  = 1'b0;
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      state_reg <= ST_IDLE;
      quo_reg   <= '0;
      rem_reg   <= '0;
      dvs_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      dbz_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      quo_reg   <= quo_next;
      rem_reg   <= rem_next;
      dvs_reg   <= dvs_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      dbz_reg   <= dbz_next;
    end
  end

  assign busy        = busy_reg;
  assign done        = done_reg;
  assign div_by_zero = dbz_reg;
  assign quotient    = quo_reg;
  assign remainder   = rem_reg;

endmodule

// File: tb/tb_divider_n_bits.sv
// Self-checking bench for divider_n_bits: arithmetic reference model checked every cycle,
// plus directed literal cases and randomized divisions.
module tb_divider_n_bits;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         aclr_n = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] dividend = '0;
  logic [N-1:0] divisor = '0;
`ifdef DIV_ABORT_EN
  logic         abort = 1'b0;
`endif
  logic         busy, done, div_by_zero;
  logic [N-1:0] quotient, remainder;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // Reference model: parameters of the most recent accepted division.
  bit m_have = 0;
  bit m_abort = 0;
  int m_a = 0, m_b = 0, m_acc = 0, m_abort_edge = 0;
  int ready_edge = 0;

  divider_n_bits #(.N(N)) dut (
    .clk         (clk),
    .aclr_n      (aclr_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
`ifdef DIV_ABORT_EN
    .abort       (abort),
`endif
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .quotient    (quotient),
    .remainder   (remainder)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, int got, int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, got, exp);
    end
  endtask

  function automatic int done_edge();
    return (m_b == 0) ? m_acc : m_acc + m_a / m_b + 1;
  endfunction

  // Outputs after edge number cyc: j edges after acceptance, min(j, Q) subtractions done.
  task automatic model_expect(output int e_busy, output int e_done, output int e_q,
                              output int e_r, output int e_dbz);
    int q, j, k;
    e_busy = 0; e_done = 0; e_q = 0; e_r = 0; e_dbz = 0;
    if (!m_have) return;
    if (m_b == 0) begin
      e_done = (cyc == m_acc) ? 1 : 0;
      e_q    = (1 << N) - 1;
      e_r    = m_a;
      e_dbz  = 1;
      return;
    end
    q = m_a / m_b;
    if (m_abort && cyc >= m_abort_edge) begin
      k = m_abort_edge - m_acc - 1;
      if (k > q) k = q;
      e_q = k;
      e_r = m_a - k * m_b;
      return;
    end
    j = cyc - m_acc;
    k = (j < q) ? j : q;
    e_busy = (j <= q) ? 1 : 0;
    e_done = (j == q + 1) ? 1 : 0;
    e_q    = k;
    e_r    = m_a - k * m_b;
  endtask

  always @(negedge clk) begin : compare
    int eb, ed, eq, er, ez;
    model_expect(eb, ed, eq, er, ez);
    check("busy", int'(busy), eb);
    check("done", int'(done), ed);
    check("quotient", int'(quotient), eq);
    check("remainder", int'(remainder), er);
    check("div_by_zero", int'(div_by_zero), ez);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(int a, int b, bit hold = 1'b0);
    while (cyc < ready_edge) step();
    dividend = N'(a);
    divisor  = N'(b);
    start    = 1'b1;
    step();
    m_have = 1; m_abort = 0; m_a = a; m_b = b; m_acc = cyc;
    ready_edge = done_edge() + 1;
    if (!hold) start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 400) begin
      step();
      n++;
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL done_timeout cyc=%0d got=0 expected=1 for %0d/%0d", cyc, m_a, m_b);
    end
    $display("[TB] txn %0d/%0d -> q=%0d r=%0d dbz=%0d done_after_edge=%0d",
             m_a, m_b, quotient, remainder, div_by_zero, cyc - m_acc + 1);
  endtask

  // With start held high, the next division is accepted two edges after the done edge.
  task automatic accept_held(int a, int b);
    int de;
    de = done_edge();
    while (cyc < de + 2) step();
    m_have = 1; m_abort = 0; m_a = a; m_b = b; m_acc = cyc;
    ready_edge = done_edge() + 1;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    #1 aclr_n = 1'b0;
    step();
    step();
    check("rst_busy", int'(busy), 0);
    check("rst_quotient", int'(quotient), 0);
    aclr_n = 1'b1;
    ready_edge = cyc;
    step();

    issue(200, 7);
    check("t1_busy_rise", int'(busy), 1);
    wait_done();
    check("t1_done_edge", cyc - m_acc + 1, 30);
    check("t1_quotient", int'(quotient), 28);
    check("t1_remainder", int'(remainder), 4);
    check("t1_dbz", int'(div_by_zero), 0);
    check("t1_busy_low", int'(busy), 0);
    // start pulsed while in DONE must be ignored
    dividend = 8'd9; divisor = 8'd2; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();

    issue(5, 9);
    wait_done();
    check("t2_done_edge", cyc - m_acc + 1, 2);
    check("t2_quotient", int'(quotient), 0);
    check("t2_remainder", int'(remainder), 5);

    issue(255, 1);
    wait_done();
    check("t3_done_edge", cyc - m_acc + 1, 257);
    check("t3_quotient", int'(quotient), 255);
    check("t3_remainder", int'(remainder), 0);

    issue(8'h3C, 0);
    wait_done();
    check("t4_done_edge", cyc - m_acc + 1, 1);
    check("t4_quotient", int'(quotient), 8'hFF);
    check("t4_remainder", int'(remainder), 8'h3C);
    check("t4_dbz", int'(div_by_zero), 1);

    issue(100, 3);
    check("t5_dbz_cleared", int'(div_by_zero), 0);
    step(); step(); step();
    dividend = 8'd250; divisor = 8'd2; start = 1'b1;
    step();
    start = 1'b0;
    wait_done();
    check("t5_done_edge", cyc - m_acc + 1, 35);
    check("t5_quotient", int'(quotient), 33);
    check("t5_remainder", int'(remainder), 1);

    issue(60, 7, 1'b1);
    dividend = 8'd90; divisor = 8'd11;
    wait_done();
    check("t6_quotient", int'(quotient), 8);
    check("t6_remainder", int'(remainder), 4);
    accept_held(90, 11);
    start = 1'b0;
    wait_done();
    check("t6b_done_edge", cyc - m_acc + 1, 10);
    check("t6b_quotient", int'(quotient), 8);
    check("t6b_remainder", int'(remainder), 2);

    // asynchronous reset at SUB edge 10 of a second 100/3 run
    issue(100, 3);
    while (cyc < m_acc + 9) step();
    aclr_n = 1'b0;
    m_have = 0;
    #1;
    check("t7_async_busy", int'(busy), 0);
    check("t7_async_quotient", int'(quotient), 0);
    check("t7_async_remainder", int'(remainder), 0);
    check("t7_async_done", int'(done), 0);
    $display("[TB] txn reset asserted mid-division at cyc=%0d", cyc);
    step();
    step();
    aclr_n = 1'b1;
    ready_edge = cyc;
    issue(77, 10);
    wait_done();
    check("t7_after_reset_quotient", int'(quotient), 7);
    check("t7_after_reset_remainder", int'(remainder), 7);

`ifdef DIV_ABORT_EN
    issue(200, 7);
    while (cyc < m_acc + 4) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    m_abort = 1;
    m_abort_edge = cyc;
    ready_edge = cyc;
    check("t8_abort_busy", int'(busy), 0);
    check("t8_abort_quotient", int'(quotient), 4);
    check("t8_abort_remainder", int'(remainder), 172);
    $display("[TB] txn 200/7 aborted -> q=%0d r=%0d", quotient, remainder);
    step(); step(); step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    step();
`endif

    for (int i = 0; i < 40; i++) begin
      int a, b, gap;
      a = int'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) b = 0;
      else if ($urandom_range(0, 1) == 0) b = int'($urandom_range(1, 15));
      else b = int'($urandom_range(1, 255));
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) step();
      issue(a, b);
      wait_done();
    end

    step();
    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
